// File: rtl/text_source.sv
// text_source: streams END_ADDRESS bytes from a 1-port text RAM onto a valid/ready byte bus.
// A credit-limited prefetch FIFO hides the RAM read latency so the stream runs at 1 byte/cycle.
module text_source #(
  parameter int END_ADDRESS = 10,
  parameter int RD_LATENCY  = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start_source,
  output logic [7:0] o_mem_address,
  output logic       o_mem_rden,
  input  logic [7:0] i_mem_q,
  output logic [7:0] o_data_out,
  output logic       o_data_valid,
  input  logic       i_data_ready,
  output logic       o_busy,
  output logic       o_done
);
  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [7:0] END_A   = 8'(END_ADDRESS);
  localparam logic [7:0] LAST_A  = 8'(END_ADDRESS - 1);
  localparam logic [7:0] DEPTH_C = 8'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_rd_addr;
  logic [RD_LATENCY-1:0] r_pipe;
  logic [RD_LATENCY-1:0] w_pipe_nxt;
  logic [7:0]            r_fifo [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [7:0]            r_count;
  logic [7:0]            w_count_nxt;
  logic [7:0]            w_inflight;
  logic                  w_rden;
  logic                  w_push;
  logic                  w_pop;

  // Number of reads issued but not yet written into the FIFO.
  always_comb begin
    w_inflight = 8'd0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_inflight = w_inflight + {7'd0, r_pipe[i]};
    end
  end

  // Credit rule: FIFO entries plus reads in flight never exceed the FIFO depth.
  assign w_rden = (r_state == S_RUN) && (r_rd_addr < END_A) &&
                  ((r_count + w_inflight) < DEPTH_C);
  assign w_push = r_pipe[RD_LATENCY-1];
  assign w_pop  = (r_count != 8'd0) && i_data_ready;

  // Read-latency shift register: tail bit marks the cycle mem_q is valid.
  always_comb begin
    w_pipe_nxt    = '0;
    w_pipe_nxt[0] = w_rden;
    for (int i = 1; i < RD_LATENCY; i++) begin
      w_pipe_nxt[i] = r_pipe[i-1];
    end
  end

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 8'd1;
      2'b01:   w_count_nxt = r_count - 8'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Next-state logic; DRAIN exits on post-update state so done follows the last transfer directly.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start_source) w_state_nxt = S_RUN;
        else                w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (w_rden && (r_rd_addr == LAST_A)) w_state_nxt = S_DRAIN;
        else                                 w_state_nxt = S_RUN;
      end
      S_DRAIN: begin
        if ((w_count_nxt == 8'd0) && (w_pipe_nxt == '0)) w_state_nxt = S_DONE;
        else                                             w_state_nxt = S_DRAIN;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Read address, in-flight pipe and FIFO bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_addr <= 8'd0;
      r_pipe    <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= 8'd0;
    end else begin
      r_pipe  <= w_pipe_nxt;
      r_count <= w_count_nxt;
      if ((r_state == S_IDLE) && i_start_source) r_rd_addr <= 8'd0;
      else if (w_rden)                           r_rd_addr <= r_rd_addr + 8'd1;
      else                                       r_rd_addr <= r_rd_addr;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      else        r_wptr <= r_wptr;
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      else        r_rptr <= r_rptr;
    end
  end

  // FIFO storage; contents are never observed while count is zero.
  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wptr] <= i_mem_q;
  end

  assign o_mem_rden    = w_rden;
  assign o_mem_address = w_rden ? r_rd_addr : 8'd0;
  assign o_data_valid  = (r_count != 8'd0);
  assign o_data_out    = o_data_valid ? r_fifo[r_rptr] : 8'd0;
  assign o_busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign o_done        = (r_state == S_DONE);

  // A push into a full FIFO means the credit rule was broken.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
                                  !(w_push && (r_count == DEPTH_C)));
endmodule
